// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: point-size mode codes,
// sequencer states and the frame-length helper.
package fft_pkg;

    localparam logic [2:0] MODE_32   = 3'd0;
    localparam logic [2:0] MODE_64   = 3'd1;
    localparam logic [2:0] MODE_128  = 3'd2;
    localparam logic [2:0] MODE_256  = 3'd3;
    localparam logic [2:0] MODE_512  = 3'd4;
    localparam logic [2:0] MODE_1024 = 3'd5;
    localparam logic [2:0] MODE_MAX  = 3'd5;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_LOAD,
        ST_GAP
    } fft_state_e;

    function automatic logic [10:0] frame_len(input logic [2:0] mode);
        return 11'd32 << mode;
    endfunction

endpackage

// File: rtl/fft_frame_cnt.sv
// Sample-within-frame counter: loads 1 on the frame's first sample, increments
// per gated sample and flags the frame's final sample index.
module fft_frame_cnt
    import fft_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [10:0] len_i,
    output logic        term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count equals the index of the sample currently being gated.
    assign term_o = ({1'b0, cnt_q} == (len_i - 11'd1));

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer gating one 32<<mode sample frame per chirp into the FFT.
// Optional drop counter output is built when FFT_FRAME_DROP_CNT_EN is defined.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode_req_sel,
    input  logic             mode_req_valid,
    input  logic             fft_ready,
    input  logic             din_en,
    input  logic             din_sop,
    input  logic [WIDTH-1:0] din_re,
    input  logic [WIDTH-1:0] din_im,
    output logic [2:0]       mode_do_sel,
    output logic             data_do_en,
    output logic [WIDTH-1:0] data_do_re,
    output logic [WIDTH-1:0] data_do_im,
    output logic             frame_do_start,
    output logic             frame_do_last,
    output logic             busy_do,
    output logic             mode_err_do,
`ifdef FFT_FRAME_DROP_CNT_EN
    output logic [15:0]      drop_cnt_do,
`endif
    output logic             sync_err_do
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    fft_state_e       state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       mode_q, mode_d;
    logic [7:0]       gap_q, gap_d;
    logic             en_q, en_d;
    logic [WIDTH-1:0] re_q, re_d;
    logic [WIDTH-1:0] im_q, im_d;
    logic             start_q, start_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             merr_q, merr_d;
    logic             serr_q, serr_d;

    logic             gated;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_term;
    logic [10:0]      len_w;

    assign len_w = frame_len(mode_q);

    fft_frame_cnt u_cnt (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .len_i  (len_w),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        mode_d   = mode_q;
        gap_d    = gap_q;
        merr_d   = 1'b0;
        serr_d   = 1'b0;
        start_d  = 1'b0;
        last_d   = 1'b0;
        gated    = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        if (mode_req_valid) begin
            if (mode_req_sel <= MODE_MAX) begin
                pend_d = mode_req_sel;
            end else begin
                merr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // The registered pending mode is applied; a same-cycle request waits.
                if (fft_ready) begin
                    state_d = ST_ARM;
                    mode_d  = pend_q;
                end
            end
            ST_ARM: begin
                if (din_en && din_sop) begin
                    gated    = 1'b1;
                    start_d  = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (din_en) begin
                    gated   = 1'b1;
                    cnt_inc = 1'b1;
                    serr_d  = din_sop;
                    if (cnt_term) begin
                        last_d  = 1'b1;
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_d   = gated;
        re_d   = gated ? din_re : '0;
        im_d   = gated ? din_im : '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= MODE_1024;
            mode_q  <= MODE_1024;
            gap_q   <= '0;
            en_q    <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            merr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            re_q    <= re_d;
            im_q    <= im_d;
            start_q <= start_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            merr_q  <= merr_d;
            serr_q  <= serr_d;
        end
    end

`ifdef FFT_FRAME_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (din_en && !gated && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_do = drop_q;
`endif

    assign mode_do_sel    = mode_q;
    assign data_do_en     = en_q;
    assign data_do_re     = re_q;
    assign data_do_im     = im_q;
    assign frame_do_start = start_q;
    assign frame_do_last  = last_q;
    assign busy_do        = busy_q;
    assign mode_err_do    = merr_q;
    assign sync_err_do    = serr_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: per-cycle comparison against a
// frame-level reference model, a mode-request vector table and directed corner cases.
module tb_fft_frame_ctrl;

    localparam int WIDTH = 16;
    localparam int GAP   = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       mode_req_sel;
    logic             mode_req_valid;
    logic             fft_ready;
    logic             din_en;
    logic             din_sop;
    logic [WIDTH-1:0] din_re;
    logic [WIDTH-1:0] din_im;
    logic [2:0]       mode_do_sel;
    logic             data_do_en;
    logic [WIDTH-1:0] data_do_re;
    logic [WIDTH-1:0] data_do_im;
    logic             frame_do_start;
    logic             frame_do_last;
    logic             busy_do;
    logic             mode_err_do;
    logic             sync_err_do;
`ifdef FFT_FRAME_DROP_CNT_EN
    logic [15:0]      drop_cnt_do;
`endif

    always #5 clock = ~clock;

    fft_frame_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
        .clock          (clock),
        .reset          (reset),
        .mode_req_sel   (mode_req_sel),
        .mode_req_valid (mode_req_valid),
        .fft_ready      (fft_ready),
        .din_en         (din_en),
        .din_sop        (din_sop),
        .din_re         (din_re),
        .din_im         (din_im),
        .mode_do_sel    (mode_do_sel),
        .data_do_en     (data_do_en),
        .data_do_re     (data_do_re),
        .data_do_im     (data_do_im),
        .frame_do_start (frame_do_start),
        .frame_do_last  (frame_do_last),
        .busy_do        (busy_do),
        .mode_err_do    (mode_err_do),
`ifdef FFT_FRAME_DROP_CNT_EN
        .drop_cnt_do    (drop_cnt_do),
`endif
        .sync_err_do    (sync_err_do)
    );

    typedef struct packed {
        logic             en;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             start;
        logic             last;
        logic [2:0]       mode;
        logic             busy;
        logic             merr;
        logic             serr;
        logic [15:0]      drop;
    } obs_t;

    typedef struct {
        logic [2:0] sel_a;
        logic [2:0] sel_b;
        logic       err_a;
        logic       err_b;
        logic [2:0] mode;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: frame progress expressed as samples still owed and gap cycles left.
    obs_t        exp_o;
    int unsigned m_pend, m_mode, m_need, m_gap, m_drop;
    bit          m_active;

    // Observations of the DUT used by the directed sequences.
    int cur_len, last_len, last_cyc, frames_done, sync_cnt, en_cnt, start_cnt, gap_obs;
    int unsigned last_mode;
    bit prev_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = 5;
        m_mode   = 5;
        m_need   = 0;
        m_gap    = 0;
        m_drop   = 0;
        m_active = 1'b0;
        exp_o    = '0;
        exp_o.mode = 3'd5;
    endtask

    task automatic model_step();
        obs_t        e;
        bit          taken;
        int unsigned pend_old;
        if (reset) begin
            model_reset();
            return;
        end
        e        = '0;
        taken    = 1'b0;
        pend_old = m_pend;
        if (mode_req_valid) begin
            if (mode_req_sel <= 3'd5) m_pend = mode_req_sel;
            else e.merr = 1'b1;
        end
        if (m_gap > 0) begin
            m_gap--;
        end else if (!m_active) begin
            if (fft_ready) begin
                m_active = 1'b1;
                m_mode   = pend_old;
                m_need   = 0;
            end
        end else if (m_need == 0) begin
            if (din_en && din_sop) begin
                taken   = 1'b1;
                e.start = 1'b1;
                m_need  = (32 << m_mode) - 1;
            end
        end else if (din_en) begin
            taken  = 1'b1;
            e.serr = din_sop;
            m_need--;
            if (m_need == 0) begin
                e.last   = 1'b1;
                m_active = 1'b0;
                m_gap    = GAP;
            end
        end
        if (taken) begin
            e.en = 1'b1;
            e.re = din_re;
            e.im = din_im;
        end else if (din_en && m_drop < 65535) begin
            m_drop++;
        end
        e.mode = 3'(m_mode);
        e.busy = m_active || (m_gap > 0);
`ifdef FFT_FRAME_DROP_CNT_EN
        e.drop = 16'(m_drop);
`endif
        exp_o = e;
    endtask

    function automatic obs_t get_act();
        obs_t a;
        a       = '0;
        a.en    = data_do_en;
        a.re    = data_do_re;
        a.im    = data_do_im;
        a.start = frame_do_start;
        a.last  = frame_do_last;
        a.mode  = mode_do_sel;
        a.busy  = busy_do;
        a.merr  = mode_err_do;
        a.serr  = sync_err_do;
`ifdef FFT_FRAME_DROP_CNT_EN
        a.drop  = drop_cnt_do;
`endif
        return a;
    endfunction

    task automatic clear_track();
        cur_len = 0; last_len = 0; last_cyc = 0; frames_done = 0; sync_cnt = 0;
        en_cnt = 0; start_cnt = 0; gap_obs = -1; last_mode = 7; prev_busy = 1'b0;
    endtask

    task automatic cycle();
        obs_t a;
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        a = get_act();
        checks++;
        if (a !== exp_o) begin
            failures++;
            $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, a, exp_o);
        end
        if (reset) begin
            cur_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (data_do_en) begin
                en_cnt++;
                if (frame_do_start) begin
                    cur_len = 1;
                    start_cnt++;
                end else begin
                    cur_len++;
                end
                if (frame_do_last) begin
                    last_len  = cur_len;
                    last_mode = mode_do_sel;
                    last_cyc  = cyc;
                    frames_done++;
                    $display("frame cyc=%0d len=%0d mode=%0d", cyc, cur_len, mode_do_sel);
                end
            end
            if (sync_err_do) sync_cnt++;
            if (prev_busy && !busy_do) gap_obs = cyc - last_cyc;
            prev_busy = busy_do;
        end
    endtask

    task automatic set_adc(input logic en, input logic sop);
        din_en  = en;
        din_sop = sop;
        din_re  = WIDTH'($urandom);
        din_im  = WIDTH'($urandom);
    endtask

    task automatic apply_reset();
        mode_req_valid = 1'b0;
        fft_ready      = 1'b0;
        set_adc(1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_track();
    endtask

    task automatic request(input logic [2:0] sel);
        mode_req_valid = 1'b1;
        mode_req_sel   = sel;
        cycle();
        mode_req_valid = 1'b0;
    endtask

    task automatic arm();
        fft_ready = 1'b1;
        cycle();
        fft_ready = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            set_adc(1'b1, 1'b0);
            cycle();
        end
    endtask

    task automatic wait_frames(input int target, input int bound, input string name);
        int n;
        n = 0;
        fft_ready = 1'b1;
        while (frames_done < target && n < bound) begin
            set_adc(1'b1, $urandom_range(0, 7) == 0);
            cycle();
            n++;
        end
        fft_ready = 1'b0;
        check({name, "_timeout"}, 32'(frames_done >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   sent;
        obs_t a;

        vecs[0] = '{3'd0, 3'd7, 1'b0, 1'b1, 3'd0};
        vecs[1] = '{3'd3, 3'd6, 1'b0, 1'b1, 3'd3};
        vecs[2] = '{3'd6, 3'd2, 1'b1, 1'b0, 3'd2};
        vecs[3] = '{3'd7, 3'd7, 1'b1, 1'b1, 3'd5};
        vecs[4] = '{3'd4, 3'd1, 1'b0, 1'b0, 3'd1};
        vecs[5] = '{3'd5, 3'd0, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{3'd2, 3'd5, 1'b0, 1'b0, 3'd5};

        mode_req_sel = 3'd0;
        model_reset();
        clear_track();
        apply_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_mode", 32'(mode_do_sel), 32'd5);
        check("reset_en", 32'(data_do_en), 32'd0);
        check("reset_busy", 32'(busy_do), 32'd0);
        check("reset_data", 32'({data_do_re, data_do_im}), 32'd0);
`ifdef FFT_FRAME_DROP_CNT_EN
        check("reset_drop", 32'(drop_cnt_do), 32'd0);
`endif

        // Mode request table: two back-to-back requests, then arm and read the applied mode.
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            request(vecs[i].sel_a);
            check("merr_a", 32'(mode_err_do), 32'(vecs[i].err_a));
            request(vecs[i].sel_b);
            check("merr_b", 32'(mode_err_do), 32'(vecs[i].err_b));
            cycle();
            check("merr_clear", 32'(mode_err_do), 32'd0);
            check("mode_pre_arm", 32'(mode_do_sel), 32'd5);
            arm();
            check("mode_applied", 32'(mode_do_sel), 32'(vecs[i].mode));
            check("busy_armed", 32'(busy_do), 32'd1);
            $display("vec %0d req=%0d,%0d mode=%0d", i, vecs[i].sel_a, vecs[i].sel_b, mode_do_sel);
        end

        // Basic 32-point frame followed by the flush gap.
        apply_reset();
        request(3'd0);
        arm();
        set_adc(1'b1, 1'b1);
        cycle();
        check("basic_start", 32'(frame_do_start), 32'd1);
        stream(31);
        check("basic_frames", 32'(frames_done), 32'd1);
        check("basic_len", 32'(last_len), 32'd32);
        check("basic_mode", last_mode, 32'd0);
        stream(10);
        check("basic_gap", 32'(gap_obs), 32'(GAP));
        check("basic_busy_low", 32'(busy_do), 32'd0);
        check("basic_gated", 32'(en_cnt), 32'd32);
        check("basic_starts", 32'(start_cnt), 32'd1);

        // Mode change requested mid-frame applies only to the next frame.
        apply_reset();
        request(3'd3);
        arm();
        set_adc(1'b1, 1'b1);
        cycle();
        stream(20);
        mode_req_valid = 1'b1;
        mode_req_sel   = 3'd5;
        set_adc(1'b1, 1'b0);
        cycle();
        mode_req_valid = 1'b0;
        check("midreq_mode_held", 32'(mode_do_sel), 32'd3);
        wait_frames(1, 400, "midreq_f1");
        check("midreq_len1", 32'(last_len), 32'd256);
        check("midreq_mode1", last_mode, 32'd3);
        wait_frames(2, 1500, "midreq_f2");
        check("midreq_len2", 32'(last_len), 32'd1024);
        check("midreq_mode2", last_mode, 32'd5);

        // Stray sop at sample 100 of a 128-point frame.
        apply_reset();
        request(3'd2);
        arm();
        set_adc(1'b1, 1'b1);
        cycle();
        stream(98);
        set_adc(1'b1, 1'b1);
        cycle();
        check("stray_serr", 32'(sync_err_do), 32'd1);
        check("stray_no_restart", 32'(frame_do_start), 32'd0);
        stream(28);
        set_adc(1'b0, 1'b0);
        cycle();
        check("stray_frames", 32'(frames_done), 32'd1);
        check("stray_len", 32'(last_len), 32'd128);
        check("stray_serr_cnt", 32'(sync_cnt), 32'd1);

        // fft_ready held low: nothing is gated.
        apply_reset();
        sent = 0;
        for (int i = 0; i < 60; i++) begin
            set_adc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
            if (din_en) sent++;
            cycle();
        end
        check("idle_gated", 32'(en_cnt), 32'd0);
        check("idle_busy", 32'(busy_do), 32'd0);
`ifdef FFT_FRAME_DROP_CNT_EN
        check("idle_drop", 32'(drop_cnt_do), 32'(sent));
`endif

        // Asynchronous reset at sample 50 of a 64-point frame.
        apply_reset();
        request(3'd1);
        arm();
        set_adc(1'b1, 1'b1);
        cycle();
        stream(49);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        a = get_act();
        checks++;
        if (a !== exp_o) begin
            failures++;
            $display("FAIL async_reset act=%h exp=%h", a, exp_o);
        end
        set_adc(1'b0, 1'b0);
        cycle();
        reset = 1'b0;
        clear_track();
        request(3'd1);
        arm();
        set_adc(1'b1, 1'b1);
        cycle();
        check("rst_restart_start", 32'(frame_do_start), 32'd1);
        check("rst_restart_en", 32'(data_do_en), 32'd1);
        stream(63);
        check("rst_restart_len", 32'(last_len), 32'd64);
        check("rst_restart_frames", 32'(frames_done), 32'd1);

        // Randomized traffic checked cycle by cycle against the model.
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) apply_reset();
            mode_req_valid = $urandom_range(0, 9) == 0;
            mode_req_sel   = 3'($urandom_range(0, 7));
            fft_ready      = $urandom_range(0, 3) != 0;
            set_adc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            cycle();
        end
        mode_req_valid = 1'b0;
        fft_ready      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
